// File: rtl/uart_tx.sv
// UART transmitter: serialises one DWIDTH-bit word per request with optional
// even/odd parity, each bit held on the line for a programmable cycle count.
module uart_tx #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] p_data,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [PWIDTH-1:0] prescale,
  output logic              tx_out,
  output logic              busy
);

  localparam int IWIDTH = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] data_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic [PWIDTH-1:0] prescale_q;
  logic [PWIDTH-1:0] cnt;
  logic [IWIDTH-1:0] bit_idx;

  logic [PWIDTH-1:0] cnt_last;
  logic              bit_done;
  logic              parity_bit;
  logic [IWIDTH-1:0] next_idx;

  // A latched prescale of zero behaves like one cycle per bit.
  assign cnt_last   = (prescale_q == '0) ? '0 : prescale_q - PWIDTH'(1);
  assign bit_done   = (cnt == cnt_last);
  assign parity_bit = (^data_q) ^ par_typ_q;
  assign next_idx   = bit_idx + IWIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_out  <= 1'b1;
          busy    <= 1'b0;
          cnt     <= '0;
          bit_idx <= '0;
          if (data_valid) begin
            data_q     <= p_data;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            prescale_q <= prescale;
            state      <= START;
            tx_out     <= 1'b0;
            busy       <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_out  <= data_q[0];
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (bit_idx == IWIDTH'(DWIDTH - 1)) begin
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= parity_bit;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= next_idx;
              tx_out  <= data_q[next_idx];
            end
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end

        PARITY: begin
          if (bit_done) begin
            cnt    <= '0;
            state  <= STOP;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end

        STOP: begin
          // The line is already high; only the frame's end needs handling.
          if (bit_done) begin
            cnt    <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end

        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and random frames compared
// cycle by cycle against a bit-list model of the serial line.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.DWIDTH(8), .PWIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic pe, input logic pt,
                                input logic [5:0] ps, input logic dv);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = dv;
  endtask

  // Expected line level for every cycle of a frame, from the framing rules.
  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] ps, input bit hold, input int limit,
                              input string name);
    bit bits[$];
    bit seq[$];
    int p;
    int ones;
    p    = (ps == 0) ? 1 : int'(ps);
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (pe) bits.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    bits.push_back(1'b1);
    foreach (bits[b]) for (int r = 0; r < p; r++) seq.push_back(bits[b]);
    for (int i = 0; i < seq.size(); i++) begin
      if (i >= limit) break;
      @(negedge clk);
      check_output($sformatf("%s tx[%0d]", name, i), tx_out, 1'(seq[i]));
      check_output($sformatf("%s busy[%0d]", name, i), busy, 1'b1);
      p_data   = 8'($urandom);
      par_en   = 1'($urandom);
      par_typ  = 1'($urandom);
      prescale = 6'($urandom);
      if (hold) data_valid = 1'b1;
      else data_valid = (i < seq.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check_output({name, " idle tx"}, tx_out, 1'b1);
    check_output({name, " idle busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [5:0] ps;

    rst = 1'b0;
    apply_stimulus(8'h00, 1'b0, 1'b0, 6'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_output("reset tx", tx_out, 1'b1);
    check_output("reset busy", busy, 1'b0);
    rst = 1'b1;
    check_idle("post reset");

    apply_stimulus(8'hA5, 1'b0, 1'b0, 6'd4, 1'b1);
    expect_frame(8'hA5, 1'b0, 1'b0, 6'd4, 1'b0, 1000, "a5_p4");
    check_idle("a5_p4");

    apply_stimulus(8'hA5, 1'b1, 1'b0, 6'd2, 1'b1);
    expect_frame(8'hA5, 1'b1, 1'b0, 6'd2, 1'b0, 1000, "a5_even_p2");
    check_idle("a5_even_p2");

    apply_stimulus(8'h01, 1'b1, 1'b1, 6'd1, 1'b1);
    expect_frame(8'h01, 1'b1, 1'b1, 6'd1, 1'b0, 1000, "01_odd_p1");
    check_idle("01_odd_p1");

    apply_stimulus(8'hFF, 1'b0, 1'b0, 6'd0, 1'b1);
    expect_frame(8'hFF, 1'b0, 1'b0, 6'd0, 1'b0, 1000, "ff_p0");
    check_idle("ff_p0");

    // data_valid held high: the second frame follows right after one idle cycle.
    apply_stimulus(8'h3C, 1'b1, 1'b1, 6'd3, 1'b1);
    expect_frame(8'h3C, 1'b1, 1'b1, 6'd3, 1'b1, 1000, "hold1");
    check_idle("hold1");
    apply_stimulus(8'hC8, 1'b0, 1'b0, 6'd2, 1'b1);
    expect_frame(8'hC8, 1'b0, 1'b0, 6'd2, 1'b0, 1000, "hold2");
    check_idle("hold2");

    // Abort during data bit 3; the frame must not resume.
    apply_stimulus(8'hA5, 1'b0, 1'b0, 6'd4, 1'b1);
    expect_frame(8'hA5, 1'b0, 1'b0, 6'd4, 1'b0, 18, "abort");
    #2 rst = 1'b0;
    #1;
    check_output("abort async tx", tx_out, 1'b1);
    check_output("abort async busy", busy, 1'b0);
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p_data = 8'($urandom);
      check_idle($sformatf("after abort %0d", i));
    end

    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = 6'($urandom_range(0, 5));
      apply_stimulus(d, pe, pt, ps, 1'b1);
      expect_frame(d, pe, pt, ps, 1'b0, 1000, $sformatf("rand%0d", n));
      check_idle($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
